// File: rtl/pc_fetch.sv
// Fetch stage of the single-cycle core: owns the architectural PC, issues one
// instruction-memory request at a time and presents the fetched word to decode.
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        instr_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  // Handshakes: a request transfers on a cycle with imem_req && imem_ready;
  // imem_req and imem_addr stay stable until then. A response is taken only in
  // S_WAIT on imem_rvalid. instr_ack transfers the held instruction and is
  // honoured only while instr_valid is high.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        npc_misaligned;
  logic [31:0] npc_commit;

  assign npc_misaligned = ALIGN_CHECK && (npc[1:0] != 2'b00);
  assign npc_commit     = ALIGN_CHECK ? npc : {npc[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      S_REQ: begin
        // Any imem_rvalid here belongs to a request cancelled by reset.
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          if (npc_misaligned) begin
            pc_d    = npc;
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = npc_commit;
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: fetch/ack sequences, backpressure, misaligned
// commit, stale response after reset, counter wrap and ALIGN_CHECK=0 rounding.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        instr_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] npc0;
  logic        ack0;
  logic        req0;
  logic [31:0] addr0;
  logic [31:0] pc0;
  logic [31:0] instr0;
  logic        valid0;
  logic        err0;
  logic [31:0] count0;
  logic        ready0;
  logic        rvalid0;
  logic [31:0] rdata0;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count;
  logic [31:0] hold_word;
  logic [31:0] cur;
  logic [31:0] nxt;

  pc_fetch #(.RESET_PC(32'h0000_0000), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .npc(npc), .instr_ack(instr_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  pc_fetch #(.RESET_PC(32'h0000_0000), .ALIGN_CHECK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .npc(npc0), .instr_ack(ack0),
    .imem_req(req0), .imem_addr(addr0), .imem_ready(ready0),
    .imem_rvalid(rvalid0), .imem_rdata(rdata0),
    .pc(pc0), .instr(instr0), .instr_valid(valid0),
    .misalign_err(err0), .fetch_count(count0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a posedge in S_REQ; returns at the negedge of the S_HOLD cycle.
  task automatic do_fetch(input logic [31:0] a, input int stall);
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      instr_ack  = 1'b1;
      npc        = $urandom;
      @(negedge clk);
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, a);
      chk("stall_pc", pc, a);
      chk("stall_valid", instr_valid, 1'b0);
      chk("stall_count", fetch_count, exp_count);
      @(posedge clk); #1;
    end
    instr_ack  = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("accept_req", imem_req, 1'b1);
    chk("accept_addr", imem_addr, a);
    exp_q.push_back(word(a));
    @(posedge clk); #1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word(a);
    @(negedge clk);
    chk("wait_req", imem_req, 1'b0);
    chk("wait_valid", instr_valid, 1'b0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    @(negedge clk);
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_pc", pc, a);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      hold_word = exp_q.pop_front();
      chk("hold_instr", instr, hold_word);
    end
  endtask

  // Entered at the negedge of an S_HOLD cycle; returns #1 after the next edge.
  task automatic do_ack(input logic [31:0] n);
    instr_ack = 1'b1;
    npc       = n;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    npc       = $urandom;
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    chk("ack_count", fetch_count, exp_count);
    chk("ack_valid", instr_valid, 1'b0);
    chk("ack_pc", pc, n);
    if (n[1:0] != 2'b00) begin
      chk("ack_err", misalign_err, 1'b1);
      chk("ack_err_req", imem_req, 1'b0);
    end else begin
      chk("ack_err", misalign_err, 1'b0);
      chk("next_req", imem_req, 1'b1);
      chk("next_addr", imem_addr, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic found;
    checks = 0; failures = 0; exp_count = 32'h0;
    rst = 1'b1; npc = 32'h0; instr_ack = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    npc0 = 32'h0; ack0 = 1'b0; ready0 = 1'b1; rvalid0 = 1'b1; rdata0 = 32'h0000_0013;
    @(posedge clk); @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_err", misalign_err, 1'b0);
    chk("rst_count", fetch_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic fetch and sequential ack
    do_fetch(32'h0, 0);
    do_ack(32'h4);
    // backpressure for 5 cycles, ack ignored outside S_HOLD
    do_fetch(32'h4, 5);
    do_ack(32'h8);
    // hold for 4 cycles, then branch
    do_fetch(32'h8, 0);
    for (int i = 0; i < 4; i++) begin
      instr_ack = 1'b0;
      npc       = $urandom;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_stable_instr", instr, hold_word);
      chk("hold_stable_pc", pc, 32'h8);
      chk("hold_stable_req", imem_req, 1'b0);
      chk("hold_stable_valid", instr_valid, 1'b1);
    end
    do_ack(32'h100);
    cur = 32'h100;
    // random aligned targets with random stalls
    for (int i = 0; i < 3; i++) begin
      nxt = 32'($urandom_range(1, 1023)) << 2;
      do_fetch(cur, $urandom_range(0, 3));
      do_ack(nxt);
      cur = nxt;
    end

    // fetch_count wrap
    do_fetch(cur, 1);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    chk("preload_count", fetch_count, exp_count);
    do_ack(cur + 32'h4);
    chk("wrap_count", fetch_count, 32'h0);
    cur = cur + 32'h4;

    // misaligned commit traps
    do_fetch(cur, 0);
    do_ack(32'h102);
    for (int i = 0; i < 4; i++) begin
      instr_ack = 1'b1;
      npc       = $urandom;
      @(negedge clk);
      chk("err_req", imem_req, 1'b0);
      chk("err_flag", misalign_err, 1'b1);
      chk("err_valid", instr_valid, 1'b0);
      chk("err_pc", pc, 32'h102);
      chk("err_count", fetch_count, exp_count);
      @(posedge clk); #1;
    end
    instr_ack = 1'b0;
    rst = 1'b1;
    #1;
    exp_count = 32'h0;
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_err", misalign_err, 1'b0);
    chk("rerst_count", fetch_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset during S_WAIT, stale response in S_REQ is dropped
    imem_ready = 1'b1;
    @(negedge clk);
    chk("refetch_req", imem_req, 1'b1);
    chk("refetch_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_valid", instr_valid, 1'b0);
    chk("midrst_req", imem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stale_valid", instr_valid, 1'b0);
      chk("stale_instr", instr, 32'h0);
      chk("stale_req", imem_req, 1'b1);
      @(posedge clk); #1;
    end
    imem_rvalid = 1'b0;
    do_fetch(32'h0, 0);
    do_ack(32'h4);

    // ALIGN_CHECK=0 rounds the committed npc down
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid0) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("a0_hold_reached", 32'(found), 32'd1);
    if (found) begin
      chk("a0_instr", instr0, 32'h0000_0013);
      ack0 = 1'b1;
      npc0 = 32'h0000_0107;
      @(posedge clk); #1;
      ack0 = 1'b0;
      npc0 = $urandom;
      @(negedge clk);
      chk("a0_pc", pc0, 32'h0000_0104);
      chk("a0_addr", addr0, 32'h0000_0104);
      chk("a0_req", req0, 1'b1);
      chk("a0_err", err0, 1'b0);
      chk("a0_count", count0, 32'h1);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Holds the architectural PC register and drives the instruction-fetch side of the single-cycle core.
- Issues one fetch request at a time to instruction memory and captures the returned word. Presents PC and instruction to decode/execute.
- When the core acknowledges the instruction, commits the next-PC value computed by the next-PC logic, then fetches again.
- It is the consumer end of the next-PC interface, and the initiator on the instruction-memory request/response interface.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ALIGN_CHECK, 1, when 1 a committed npc with npc[1:0]!=0 traps into the error state; when 0 the low two bits are forced to 0 on commit.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
npc  input  32  next PC from next-PC logic; sampled only on the instr_ack cycle.
instr_ack  input  1  core has consumed the current instruction; commit npc.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; equals pc whenever imem_req=1.
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  read data valid.
imem_rdata  input  32  instruction word.
pc  output  32  current PC.
instr  output  32  captured instruction; valid only while instr_valid=1.
instr_valid  output  1  instr holds the word fetched from pc.
misalign_err  output  1  sticky; misaligned npc was committed.
fetch_count  output  32  number of instructions acknowledged; wraps modulo 2^32.

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0, misalign_err=0, fetch_count=0.
  - imem_req=1 in the first cycle after rst deasserts.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> S_WAIT; otherwise remain, with address held stable.
  - imem_rvalid is ignored in this state, so stale responses are discarded.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> instr<=imem_rdata, instr_valid<=1, -> S_HOLD.
  - A response in the same cycle as acceptance is not supported; minimum fetch latency is ready-edge + 1 cycle.
- S_HOLD:
  - instr_valid=1; instr and pc held stable.
  - On instr_ack=1: fetch_count<=fetch_count+1, instr_valid<=0.
  - If ALIGN_CHECK=1 and npc[1:0]!=0: pc<=npc, misalign_err<=1, -> S_ERR.
  - Otherwise: pc<=(ALIGN_CHECK ? npc : {npc[31:2],2'b00}), -> S_REQ.
  - Next imem_req therefore rises exactly one cycle after the ack cycle, with imem_addr equal to the committed npc.
- instr_ack outside S_HOLD: ignored; pc and fetch_count unchanged.
- S_ERR:
  - imem_req=0, instr_valid=0, misalign_err=1.
  - Terminal until rst.
- Throughput: best case one instruction per 3 cycles (REQ, WAIT, HOLD with immediate ack).
- fetch_count: 32'hFFFF_FFFF + 1 -> 0; no flag.
- Reset mid-fetch: all state cleared at once. The memory must share rst; a response already in flight that arrives in S_REQ is dropped.
- npc is combinational from outside and may change freely except on the instr_ack cycle in S_HOLD.

Test Plan:
1. Reset release, RESET_PC=0, memory ready=1 with 1-cycle latency returning 32'h00000013:
   - imem_req at cycle 1 with addr 0; instr_valid at cycle 3 with instr=32'h00000013.
   - ack with npc=4 -> imem_addr=4 on the next cycle; fetch_count=1.
2. Backpressure: imem_ready low for 5 cycles:
   - imem_req stays 1 with addr stable for 5 cycles, no state advance.
   - Acceptance on cycle 6; instr_valid appears only after the following rvalid.
3. Hold, then branch: hold instr_ack=0 for 4 cycles in S_HOLD:
   - instr/pc stable, no imem_req.
   - ack with npc=32'h0000_0100 -> next request addr 32'h100.
4. Misaligned commit, ALIGN_CHECK=1, npc=32'h0000_0102:
   - misalign_err=1, pc=32'h102, imem_req stays 0 indefinitely.
   - rst clears the error and refetches at RESET_PC.
5. Stale response: assert rst while in S_WAIT, then deliver rvalid during S_REQ after reset:
   - instr_valid stays 0 and instr=0 until a fresh accepted request's response arrives.
6. Counter wrap: force 2^32 acks (or preload via a bench-side hierarchical force to 32'hFFFF_FFFF), then one ack -> fetch_count=0. Also check that ALIGN_CHECK=0 with npc=32'h107 commits pc=32'h104.
